// File: rtl/mbist_mux_pkg.sv
// rtl/mbist_mux_pkg.sv - shared types, state codes and helpers for the MBIST mux/demux
package mbist_mux_pkg;

  localparam int MAX_READ_LAT = 4;
  localparam int TAG_SEL_W    = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [TAG_SEL_W-1:0] sel;
    logic                 is_read;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mbist_lat_pipe.sv
// rtl/mbist_lat_pipe.sv - shift register carrying read tags alongside the memory latency
module mbist_lat_pipe
  import mbist_mux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mbist_mux_demux_pipe.sv
// rtl/mbist_mux_demux_pipe.sv - routes one MBIST controller to NUM_MEM memories with read return
module mbist_mux_demux_pipe
  import mbist_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_MEM    = 8,
  parameter int SEL_WIDTH  = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEL_WIDTH-1:0]          memory_sel,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          write_read_mbist,
  input  logic [DATA_WIDTH-1:0]         wdata_mbist,
  input  logic [ADDR_WIDTH-1:0]         address_mbist,
  output logic [DATA_WIDTH-1:0]         rdata_mbist,
  output logic                          rdata_valid,
  output logic                          sel_err,
  output logic [NUM_MEM-1:0]            mem_ce,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [NUM_MEM*DATA_WIDTH-1:0] mem_rdata
);

  localparam int LAT   = (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : ((READ_LAT < 1) ? 1 : READ_LAT);
  localparam int DEPTH = LAT + 1;
  localparam int CNT_W = clog2(LAT + 3);

  logic                  r_rst_done;
  logic [1:0]            r_state;
  logic [SEL_WIDTH-1:0]  r_cur_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_sel_diff;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_in_range;
  logic                  w_gen;
  tag_t                  w_tag_in;
  tag_t                  w_tag_out;
  logic [DATA_WIDTH-1:0] w_rdata_sel;
  logic [NUM_MEM-1:0]    w_ce_next;

  assign w_sel_diff  = (memory_sel != r_cur_sel);
  assign w_in_range  = ({1'b0, memory_sel} < (SEL_WIDTH+1)'(NUM_MEM));
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !write_read_mbist;
  assign w_gen       = w_tag_out.is_read;
  assign w_cnt_next  = r_cnt + CNT_W'(w_rd_accept) - CNT_W'(w_gen);

  // Ready drops combinationally so a select change never slips in under live reads.
  always_comb begin
    req_ready = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
      S_RUN:   req_ready = !(req_valid && w_sel_diff);
      default: req_ready = 1'b0;
    endcase
    req_ready = req_ready && r_rst_done;
  end

  always_comb begin
    w_tag_in.sel     = w_rd_accept ? TAG_SEL_W'(memory_sel) : '0;
    w_tag_in.is_read = w_rd_accept;
  end

  // Out-of-range selects match no channel: no chip enable, zero read data.
  always_comb begin
    w_ce_next = '0;
    for (int k = 0; k < NUM_MEM; k++) begin
      if (w_accept && (memory_sel == SEL_WIDTH'(k))) w_ce_next[k] = 1'b1;
    end
  end

  always_comb begin
    w_rdata_sel = '0;
    for (int k = 0; k < NUM_MEM; k++) begin
      if (w_tag_out.sel == TAG_SEL_W'(k)) w_rdata_sel = mem_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  mbist_lat_pipe #(
    .DEPTH (DEPTH)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rst_done  <= 1'b0;
      r_state     <= S_IDLE;
      r_cur_sel   <= '0;
      r_cnt       <= '0;
      mem_ce      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_valid <= 1'b0;
      rdata_mbist <= '0;
      sel_err     <= 1'b0;
    end else begin
      r_rst_done  <= 1'b1;
      r_cnt       <= w_cnt_next;
      mem_ce      <= w_ce_next;
      rdata_valid <= w_gen;
      if (w_accept) begin
        mem_we    <= write_read_mbist;
        mem_addr  <= address_mbist;
        mem_wdata <= wdata_mbist;
      end
      if (w_accept && !w_in_range) sel_err <= 1'b1;
      if (w_gen) rdata_mbist <= w_rdata_sel;
      case (r_state)
        S_IDLE: begin
          if (w_accept)    r_cur_sel <= memory_sel;
          if (w_rd_accept) r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_cnt_next == '0)             r_state <= S_IDLE;
          else if (req_valid && w_sel_diff) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_cnt_next == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_mux_demux_pipe.sv
// tb/tb_mbist_mux_demux_pipe.sv - directed self-checking bench for mbist_mux_demux_pipe
module tb_mbist_mux_demux_pipe;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int NM = 8;
  localparam int SW = 4;

  logic              clk;
  logic              rst_n;
  logic [SW-1:0]     memory_sel;
  logic              req_valid;
  logic              req_ready;
  logic              write_read_mbist;
  logic [DW-1:0]     wdata_mbist;
  logic [AW-1:0]     address_mbist;
  logic [DW-1:0]     rdata_mbist;
  logic              rdata_valid;
  logic              sel_err;
  logic [NM-1:0]     mem_ce;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [NM*DW-1:0]  mem_rdata;

  int n_total;
  int n_bad;

  mbist_mux_demux_pipe #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_MEM    (NM),
    .SEL_WIDTH  (SW),
    .READ_LAT   (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .memory_sel       (memory_sel),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .write_read_mbist (write_read_mbist),
    .wdata_mbist      (wdata_mbist),
    .address_mbist    (address_mbist),
    .rdata_mbist      (rdata_mbist),
    .rdata_valid      (rdata_valid),
    .sel_err          (sel_err),
    .mem_ce           (mem_ce),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_fn(input int k, input logic [AW-1:0] a);
    if (k == 3) return 64'h1234;
    return (64'(k) << 16) | 64'(a);
  endfunction

  // Memory model: one cycle of read latency after the chip-enable cycle.
  always @(posedge clk) begin
    if (!rst_n) mem_rdata <= '0;
    else begin
      for (int k = 0; k < NM; k++) begin
        if (mem_ce[k] && !mem_we) mem_rdata[k*DW +: DW] <= model_fn(k, mem_addr);
      end
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [SW-1:0] sel,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid        = v;
    write_read_mbist = we;
    memory_sel       = sel;
    address_mbist    = a;
    wdata_mbist      = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 64'(req_ready), 64'd0);
    check_val({tag, "_ce"}, 64'(mem_ce), 64'd0);
    check_val({tag, "_we"}, 64'(mem_we), 64'd0);
    check_val({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_val({tag, "_wdata"}, mem_wdata, 64'd0);
    check_val({tag, "_rvalid"}, 64'(rdata_valid), 64'd0);
    check_val({tag, "_rdata"}, rdata_mbist, 64'd0);
    check_val({tag, "_selerr"}, 64'(sel_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    #1 check_all_zero("rst");
    rst_n = 1'b1;
    next_cycle();
    #1 check_val("ready_after_rst", 64'(req_ready), 64'd1);
    next_cycle();

    // single write to sel 3
    drive(1, 1, 3, 16'h0010, 64'hA5A5_A5A5_A5A5_A5A5);
    #1 check_val("wr_ready", 64'(req_ready), 64'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1;
    check_val("wr_ce", 64'(mem_ce), 64'h08);
    check_val("wr_we", 64'(mem_we), 64'd1);
    check_val("wr_addr", 64'(mem_addr), 64'h0010);
    check_val("wr_wdata", mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check_val("wr_rvalid0", 64'(rdata_valid), 64'd0);
    next_cycle();
    #1 check_val("wr_ce_off", 64'(mem_ce), 64'h00);
    check_val("wr_rvalid1", 64'(rdata_valid), 64'd0);
    next_cycle();
    #1 check_val("wr_rvalid2", 64'(rdata_valid), 64'd0);
    next_cycle();

    // single read from sel 3
    drive(1, 0, 3, 16'h0004, 0);
    #1 check_val("rd_ready0", 64'(req_ready), 64'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1 check_val("rd_ce", 64'(mem_ce), 64'h08);
    check_val("rd_we", 64'(mem_we), 64'd0);
    check_val("rd_ready1", 64'(req_ready), 64'd1);
    next_cycle();
    #1 check_val("rd_rvalid_early", 64'(rdata_valid), 64'd0);
    check_val("rd_ready2", 64'(req_ready), 64'd1);
    next_cycle();
    #1 check_val("rd_rvalid", 64'(rdata_valid), 64'd1);
    check_val("rd_rdata", rdata_mbist, 64'h1234);
    check_val("rd_ready3", 64'(req_ready), 64'd1);
    next_cycle();
    #1 check_val("rd_rvalid_off", 64'(rdata_valid), 64'd0);
    check_val("rd_rdata_hold", rdata_mbist, 64'h1234);
    next_cycle();

    // four back-to-back reads on sel 5
    for (int j = 0; j < 8; j++) begin
      if (j < 4) drive(1, 0, 5, AW'(j), 0);
      else       drive(0, 0, 0, 0, 0);
      #1;
      if (j < 4) check_val($sformatf("b2b_ready%0d", j), 64'(req_ready), 64'd1);
      if (j >= 1 && j <= 4) check_val($sformatf("b2b_ce%0d", j), 64'(mem_ce), 64'h20);
      check_val($sformatf("b2b_rvalid%0d", j), 64'(rdata_valid), (j >= 3 && j <= 6) ? 64'd1 : 64'd0);
      if (j >= 3 && j <= 6) check_val($sformatf("b2b_rdata%0d", j), rdata_mbist, 64'h50000 + 64'(j - 3));
      next_cycle();
    end

    // select change while a read is in flight
    drive(1, 0, 2, 16'h0020, 0);
    #1 check_val("drn_ready0", 64'(req_ready), 64'd1);
    next_cycle();
    drive(1, 0, 6, 16'h0061, 0);
    #1 check_val("drn_ready1", 64'(req_ready), 64'd0);
    check_val("drn_ce1", 64'(mem_ce), 64'h04);
    next_cycle();
    #1 check_val("drn_ready2", 64'(req_ready), 64'd0);
    check_val("drn_ce2", 64'(mem_ce), 64'h00);
    check_val("drn_rvalid2", 64'(rdata_valid), 64'd0);
    next_cycle();
    #1 check_val("drn_ready3", 64'(req_ready), 64'd1);
    check_val("drn_ce3", 64'(mem_ce), 64'h00);
    check_val("drn_rvalid3", 64'(rdata_valid), 64'd1);
    check_val("drn_rdata3", rdata_mbist, 64'h20020);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1 check_val("drn_ce4", 64'(mem_ce), 64'h40);
    next_cycle();
    #1 check_val("drn_rvalid5", 64'(rdata_valid), 64'd0);
    next_cycle();
    #1 check_val("drn_rvalid6", 64'(rdata_valid), 64'd1);
    check_val("drn_rdata6", rdata_mbist, 64'h60061);
    next_cycle();

    // out-of-range select
    #1 check_val("oor_selerr_pre", 64'(sel_err), 64'd0);
    drive(1, 0, 9, 16'h0005, 0);
    #1 check_val("oor_ready", 64'(req_ready), 64'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1 check_val("oor_ce1", 64'(mem_ce), 64'h00);
    check_val("oor_selerr1", 64'(sel_err), 64'd1);
    next_cycle();
    #1 check_val("oor_ce2", 64'(mem_ce), 64'h00);
    check_val("oor_rvalid2", 64'(rdata_valid), 64'd0);
    next_cycle();
    #1 check_val("oor_rvalid3", 64'(rdata_valid), 64'd1);
    check_val("oor_rdata3", rdata_mbist, 64'd0);
    check_val("oor_selerr3", 64'(sel_err), 64'd1);
    next_cycle();
    #1 check_val("oor_selerr4", 64'(sel_err), 64'd1);
    next_cycle();

    // reset right after a read accept
    drive(1, 0, 1, 16'h0007, 0);
    #1 check_val("mrst_ready", 64'(req_ready), 64'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 check_val("mrst_ce", 64'(mem_ce), 64'h02);
    next_cycle();
    #1 check_all_zero("mrst");
    rst_n = 1'b1;
    next_cycle();
    #1 check_val("mrst_ready_back", 64'(req_ready), 64'd1);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("mrst_no_rvalid%0d", j), 64'(rdata_valid), 64'd0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
